// File: rtl/demux_top.sv
// rtl/demux_top.sv - one-hot word demux into per-instance 1-deep registered slots (optional DEMUX_DROP_CNT_EN drop counter)
module demux_top #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [W_WIDTH-1:0]             data_in,
    input  logic [NUM_SW_INST-1:0]         sel,
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic [W_WIDTH*NUM_SW_INST-1:0] data_out,
    output logic [NUM_SW_INST-1:0]         valid_out,
    input  logic [NUM_SW_INST-1:0]         ready_in,
    output logic                           sel_err
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]                    drop_cnt
`endif
);

    localparam logic [NUM_SW_INST-1:0] ONE = NUM_SW_INST'(1);

    logic [W_WIDTH*NUM_SW_INST-1:0] r_data;
    logic [NUM_SW_INST-1:0]         r_valid;
    logic                           r_sel_err;

    logic                           w_legal;
    logic [NUM_SW_INST-1:0]         w_slot_free;
    logic                           w_ready_out;
    logic [NUM_SW_INST-1:0]         w_load;
    logic                           w_drop;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign w_legal = (sel != '0) && ((sel & (sel - ONE)) == '0);

    // A slot can take a word if it is empty or being consumed this same cycle.
    assign w_slot_free = ~r_valid | ready_in;

    // Illegal selects are always accepted (and dropped) so they never stall upstream.
    assign w_ready_out = ~w_legal | (|(sel & w_slot_free));

    assign w_load = sel & {NUM_SW_INST{valid_in & w_legal & w_ready_out}};
    assign w_drop = valid_in & ~w_legal;

    // Slot registers: load wins over drain so a slot streams at one word per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            r_data    <= '0;
            r_sel_err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_SW_INST; k++) begin
                if (w_load[k]) begin
                    r_data[k*W_WIDTH +: W_WIDTH] <= data_in;
                    r_valid[k]                   <= 1'b1;
                end else if (ready_in[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
            r_sel_err <= w_drop;
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of words dropped for an illegal select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= 16'h0000;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'h0001;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign ready_out = w_ready_out;
    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_demux_top.sv
// tb/tb_demux_top.sv - randomized self-checking bench for demux_top
module tb_demux_top;

    localparam int N = 5;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [W-1:0]   data_in;
    logic [N-1:0]   sel;
    logic           valid_in;
    logic           ready_out;
    logic [W*N-1:0] data_out;
    logic [N-1:0]   valid_out;
    logic [N-1:0]   ready_in;
    logic           sel_err;
`ifdef DEMUX_DROP_CNT_EN
    logic [15:0]    drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural model: one holding register per slot plus error/drop bookkeeping.
    bit          m_valid [N];
    logic [W-1:0] m_data [N];
    bit          m_err;
    int          m_cnt;

    demux_top #(.NUM_SW_INST(N), .W_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .sel       (sel),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .sel_err   (sel_err)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_ready();
        int n = 0;
        int idx = 0;
        for (int k = 0; k < N; k++) if (sel[k]) begin n++; idx = k; end
        if (n != 1) return 1'b1;
        return !m_valid[idx] || ready_in[idx];
    endfunction

    function automatic logic [N-1:0] exp_valid();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_valid[k];
        return v;
    endfunction

    function automatic logic [W*N-1:0] exp_data();
        logic [W*N-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = m_data[k];
        return d;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int n = 0;
        int idx = 0;
        bit take;
        if (rst) begin
            for (int k = 0; k < N; k++) begin m_valid[k] = 0; m_data[k] = '0; end
            m_err = 0;
            m_cnt = 0;
        end else begin
            for (int k = 0; k < N; k++) if (sel[k]) begin n++; idx = k; end
            take = valid_in && (n == 1) && (!m_valid[idx] || ready_in[idx]);
            for (int k = 0; k < N; k++) if (m_valid[k] && ready_in[k]) m_valid[k] = 0;
            if (take) begin m_valid[idx] = 1; m_data[idx] = data_in; end
            m_err = valid_in && (n != 1);
            if (m_err && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] s, input logic [W-1:0] d, input logic [N-1:0] ri);
        valid_in = v; sel = s; data_in = d; ready_in = ri;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5'b00001, 32'h1234_5678, 5'b00000);
        tick();
        checks++;
        if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready_out: got %b expected 1", ready_out); end
        tick();
        rst = 1'b0;
        drive(1'b0, 5'b00000, 32'h0, 5'b00000);
        checks++;
        if (valid_out !== 5'b00000) begin failures++; $display("FAIL reset_valid_out: got %b expected 00000", valid_out); end
        checks++;
        if (data_out !== '0) begin failures++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        checks++;
        if (sel_err !== 1'b0) begin failures++; $display("FAIL reset_sel_err: got %b expected 0", sel_err); end
    endtask

    task automatic test_single_route();
        drive(1'b1, 5'b00100, 32'hDEAD_BEEF, 5'b00000);
        checks++;
        if (ready_out !== 1'b1) begin failures++; $display("FAIL route_ready_empty: got %b expected 1", ready_out); end
        tick();
        checks++;
        if (valid_out !== 5'b00100) begin failures++; $display("FAIL route_valid: got %b expected 00100", valid_out); end
        checks++;
        if (data_out[2*W +: W] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL route_slot2: got %h expected deadbeef", data_out[2*W +: W]); end
        drive(1'b1, 5'b00100, 32'h1234_5678, 5'b00000);
        checks++;
        if (ready_out !== 1'b0) begin failures++; $display("FAIL route_stall_ready: got %b expected 0", ready_out); end
        tick();
        checks++;
        if (data_out[2*W +: W] !== 32'hDEAD_BEEF || valid_out !== 5'b00100) begin
            failures++; $display("FAIL route_hold: got %h/%b expected deadbeef/00100", data_out[2*W +: W], valid_out);
        end
        drive(1'b1, 5'b00100, 32'h1234_5678, 5'b00100);
        checks++;
        if (ready_out !== 1'b1) begin failures++; $display("FAIL route_drain_ready: got %b expected 1", ready_out); end
        tick();
        checks++;
        if (data_out[2*W +: W] !== 32'h1234_5678 || valid_out !== 5'b00100) begin
            failures++; $display("FAIL route_reload: got %h/%b expected 12345678/00100", data_out[2*W +: W], valid_out);
        end
        drive(1'b0, 5'b00000, 32'h0, 5'b00100);
        tick();
        checks++;
        if (valid_out !== 5'b00000) begin failures++; $display("FAIL route_drain: got %b expected 00000", valid_out); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 5'b00010, W'(i), 5'b00010);
            checks++;
            if (ready_out !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, ready_out); end
            tick();
            checks++;
            if (data_out[1*W +: W] !== W'(i) || valid_out[1] !== 1'b1) begin
                failures++; $display("FAIL b2b_slot1[%0d]: got %h/%b expected %h/1", i, data_out[1*W +: W], valid_out[1], i);
            end
        end
        drive(1'b0, 5'b00000, 32'h0, 5'b00010);
        tick();
        checks++;
        if (valid_out !== 5'b00000) begin failures++; $display("FAIL b2b_final: got %b expected 00000", valid_out); end
    endtask

    task automatic test_illegal_sel();
        logic [N-1:0] bad [2];
        bad[0] = 5'b00000;
        bad[1] = 5'b10001;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, bad[i], $urandom, 5'b00000);
            checks++;
            if (ready_out !== 1'b1) begin failures++; $display("FAIL illegal_ready[%0d]: got %b expected 1", i, ready_out); end
            tick();
            checks++;
            if (sel_err !== 1'b1) begin failures++; $display("FAIL illegal_sel_err[%0d]: got %b expected 1", i, sel_err); end
            checks++;
            if (valid_out !== 5'b00000) begin failures++; $display("FAIL illegal_valid[%0d]: got %b expected 00000", i, valid_out); end
        end
        drive(1'b0, 5'b00000, 32'h0, 5'b00000);
        tick();
        checks++;
        if (sel_err !== 1'b0) begin failures++; $display("FAIL illegal_pulse_end: got %b expected 0", sel_err); end
`ifdef DEMUX_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd2) begin failures++; $display("FAIL illegal_drop_cnt: got %0d expected 2", drop_cnt); end
`endif
    endtask

    task automatic test_parallel_slots();
        drive(1'b1, 5'b00001, 32'hA0, 5'b00000); tick();
        drive(1'b1, 5'b01000, 32'hA3, 5'b00000); tick();
        drive(1'b1, 5'b10000, 32'hA4, 5'b00000); tick();
        checks++;
        if (valid_out !== 5'b11001) begin failures++; $display("FAIL par_fill: got %b expected 11001", valid_out); end
        drive(1'b0, 5'b00000, 32'h0, 5'b11001);
        tick();
        ready_in = 5'b00000;
        checks++;
        if (valid_out !== 5'b00000) begin failures++; $display("FAIL par_drain: got %b expected 00000", valid_out); end
        checks++;
        if (data_out[0 +: W] !== 32'hA0 || data_out[3*W +: W] !== 32'hA3 || data_out[4*W +: W] !== 32'hA4) begin
            failures++; $display("FAIL par_retain: got %h expected slots a0/a3/a4", data_out);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 5'b00001, 32'h5555_0000, 5'b00000); tick();
        drive(1'b1, 5'b00100, 32'h5555_0002, 5'b00000); tick();
        checks++;
        if (valid_out !== 5'b00101) begin failures++; $display("FAIL midrst_fill: got %b expected 00101", valid_out); end
        rst = 1'b1;
        drive(1'b1, 5'b00000, 32'h0, 5'b00000);
        tick();
        rst = 1'b0;
        drive(1'b0, 5'b00000, 32'h0, 5'b00000);
        checks++;
        if (valid_out !== 5'b00000 || data_out !== '0 || sel_err !== 1'b0) begin
            failures++; $display("FAIL midrst_clear: got %b/%h/%b expected 00000/0/0", valid_out, data_out, sel_err);
        end
        drive(1'b1, 5'b01000, 32'hCAFE_F00D, 5'b00000);
        tick();
        checks++;
        if (valid_out !== 5'b01000 || data_out[3*W +: W] !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL midrst_accept: got %b/%h expected 01000/cafef00d", valid_out, data_out[3*W +: W]);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] s;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0) s = N'(1) << $urandom_range(0, N-1);
            else s = N'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            drive(1'($urandom), s, $urandom, N'($urandom));
            if (c > 0 && !rst) begin
                checks++;
                if (ready_out !== exp_ready()) begin failures++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, ready_out, exp_ready()); end
            end
            tick();
            checks++;
            if (valid_out !== exp_valid()) begin failures++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, valid_out, exp_valid()); end
            checks++;
            if (data_out !== exp_data()) begin failures++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, data_out, exp_data()); end
            checks++;
            if (sel_err !== m_err) begin failures++; $display("FAIL rnd_sel_err[%0d]: got %b expected %b", c, sel_err, m_err); end
`ifdef DEMUX_DROP_CNT_EN
            checks++;
            if (drop_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL rnd_drop_cnt[%0d]: got %0d expected %0d", c, drop_cnt, m_cnt); end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; sel = '0; data_in = '0; ready_in = '0;
        for (int k = 0; k < N; k++) begin m_valid[k] = 0; m_data[k] = '0; end
        m_err = 0;
        m_cnt = 0;
        @(negedge clk);
        test_reset();
        test_single_route();
        test_back_to_back();
        test_illegal_sel();
        test_parallel_slots();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
